// File: rtl/data_memory_responder.sv
// data_memory_responder: RAM-bus responder with programmable wait states.
// Optional out-of-range checking is enabled by defining MEM_BOUNDS_ERR_EN.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   req     access request, sampled only while idle
//   rw      1 = write, 0 = read (latched with req)
//   addbus  16-bit word address (latched with req)
//   ramin   write data (latched with req)
//   ramout  read data, held until the next read completes
//   ready   one-cycle completion pulse
//   busy    high while a request is in flight
//   err     out-of-range flag for the ready cycle (0 unless MEM_BOUNDS_ERR_EN)
module data_memory_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [15:0]       addbus,
    input  logic [DATA_W-1:0] ramin,
    output logic [DATA_W-1:0] ramout,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t            state;
    state_t            state_d;
    logic [3:0]        cnt;
    logic              rw_q;
    logic [15:0]       addr_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] idx;
    logic              oor;
    logic              accept;
    logic              access;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign idx = addr_q[ADDR_W-1:0];

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        access  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                access  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ramout <= '0;
            ready  <= 1'b0;
            busy   <= 1'b0;
            cnt    <= 4'd0;
        end else begin
            // ready lands in the first idle cycle after the access
            ready <= access;
            if (accept) begin
                busy <= 1'b1;
                cnt  <= WS;
            end
            if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                busy <= 1'b0;
                if (!rw_q) begin
                    ramout <= oor ? '0 : mem[idx];
                end
            end
        end
    end

    // Request copy; bus changes while busy never reach these.
    always_ff @(posedge clk) begin
        if (accept) begin
            rw_q   <= rw;
            addr_q <= addbus;
            data_q <= ramin;
        end
    end

    // Store is not reset; a reset in the access cycle cancels the write.
    always_ff @(posedge clk) begin
        if (!reset && access && rw_q && !oor) begin
            mem[idx] <= data_q;
        end
    end

`ifdef MEM_BOUNDS_ERR_EN
    logic err_q;

    assign oor = |addr_q[15:ADDR_W];
    assign err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= access && oor;
        end
    end
`else
    // Upper address bits alias onto the store.
    logic unused_hi;

    assign unused_hi = ^addr_q[15:ADDR_W];
    assign oor       = 1'b0;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: table-driven transactions with an
// expected-result queue, plus latency, back-to-back, reset and range cases.
module tb_data_memory_responder;

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] exp_out;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        logic        err;
    } exp_t;

`ifdef MEM_BOUNDS_ERR_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] addbus = '0;
    logic [31:0] ramin = '0;

    logic [31:0] ramout, ramout_0, ramout_5;
    logic        ready, ready_0, ready_5;
    logic        busy, busy_0, busy_5;
    logic        err, err_0, err_5;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[9];

    always #5 clk = ~clk;

    data_memory_responder dut (
        .clk(clk), .reset(reset), .req(req), .rw(rw),
        .addbus(addbus), .ramin(ramin), .ramout(ramout),
        .ready(ready), .busy(busy), .err(err)
    );

    data_memory_responder #(.WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .reset(reset), .req(req), .rw(rw),
        .addbus(addbus), .ramin(ramin), .ramout(ramout_0),
        .ready(ready_0), .busy(busy_0), .err(err_0)
    );

    data_memory_responder #(.WAIT_STATES(5)) dut_ws5 (
        .clk(clk), .reset(reset), .req(req), .rw(rw),
        .addbus(addbus), .ramin(ramin), .ramout(ramout_5),
        .ready(ready_5), .busy(busy_5), .err(err_5)
    );

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (!ready && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic pop_check(input string n);
        exp_t e;
        checks++;
        if (!ready) begin
            errors++;
            $display("FAIL %s timeout: ready=%b expected 1", n, ready);
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: ready with empty queue, expected none", n);
        end else begin
            e = sb.pop_front();
            check({n, " ramout"}, ramout, e.out);
            check({n, " err"}, 32'(err), 32'(e.err));
        end
    endtask

    task automatic push(input logic [31:0] o, input logic e_err);
        exp_t e;
        e.out = o;
        e.err = e_err;
        sb.push_back(e);
    endtask

    // Call one cycle-phase after an edge with the DUT idle.
    task automatic txn(input vec_t v, input string n);
        int lat;
        push(v.exp_out, v.exp_err);
        req    = 1'b1;
        rw     = v.w;
        addbus = v.a;
        ramin  = v.d;
        tick();
        req    = 1'b0;
        rw     = ~v.w;
        addbus = 16'($urandom);
        ramin  = $urandom;
        wait_ready(lat);
        check({n, " latency"}, 32'(lat + 1), 32'd4);
        pop_check(n);
        tick();
        check({n, " ready width"}, 32'(ready), 32'd0);
    endtask

    initial begin
        int l0, l2, l5, b0, b2, b5, r0, r2, r5, lat, rcnt;
        vec_t v;

        vecs[0] = '{1'b1, 16'h0005, 32'h0000_1000, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 16'h0005, 32'h0,         32'h0000_1000, 1'b0};
        vecs[2] = '{1'b1, 16'h0010, 32'h0BAD_F00D, 32'h0000_1000, 1'b0};
        vecs[3] = '{1'b0, 16'h0010, 32'h0,         32'h0BAD_F00D, 1'b0};
        vecs[4] = '{1'b1, 16'h0020, 32'h1111_1111, 32'h0BAD_F00D, 1'b0};
        vecs[5] = '{1'b1, 16'h00FF, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0};
        vecs[6] = '{1'b0, 16'h00FF, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[7] = '{1'b0, 16'h0005, 32'h0,         32'h0000_1000, 1'b0};
        vecs[8] = '{1'b0, 16'h0020, 32'h0,         32'h1111_1111, 1'b0};

        // Reset
        tick();
        tick();
        reset = 1'b0;
        check("reset ready", 32'(ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset ramout", ramout, 32'd0);
        check("reset err", 32'(err), 32'd0);

        // Latency sweep across WAIT_STATES = 0, 2, 5
        l0 = -1; l2 = -1; l5 = -1;
        b0 = 0; b2 = 0; b5 = 0;
        r0 = 0; r2 = 0; r5 = 0;
        req = 1'b1; rw = 1'b1; addbus = 16'h0077; ramin = 32'h77;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) req = 1'b0;
            if (ready_0 && l0 < 0) l0 = i;
            if (ready && l2 < 0) l2 = i;
            if (ready_5 && l5 < 0) l5 = i;
            b0 += int'(busy_0); b2 += int'(busy); b5 += int'(busy_5);
            r0 += int'(ready_0); r2 += int'(ready); r5 += int'(ready_5);
        end
        check("lat ws0", 32'(l0), 32'd2);
        check("lat ws2", 32'(l2), 32'd4);
        check("lat ws5", 32'(l5), 32'd7);
        check("busy ws0", 32'(b0), 32'd1);
        check("busy ws2", 32'(b2), 32'd3);
        check("busy ws5", 32'(b5), 32'd6);
        check("pulses ws0", 32'(r0), 32'd1);
        check("pulses ws2", 32'(r2), 32'd1);
        check("pulses ws5", 32'(r5), 32'd1);
        check("write keeps ramout", ramout, 32'd0);

        // Table of single transactions
        for (int i = 0; i < 9; i++) begin
            txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back with req held and bus changing mid-flight
        push(32'h1111_1111, 1'b0);
        req = 1'b1; rw = 1'b1; addbus = 16'h0010; ramin = 32'hA5A5_A5A5;
        tick();
        rw = 1'b0; addbus = 16'h0033; ramin = 32'h5A5A_0000;
        wait_ready(lat);
        check("b2b wr latency", 32'(lat + 1), 32'd4);
        pop_check("b2b wr");
        addbus = 16'h0010;
        push(32'hA5A5_A5A5, 1'b0);
        tick();
        req = 1'b0; addbus = 16'h0044;
        check("b2b accepted busy", 32'(busy), 32'd1);
        wait_ready(lat);
        check("b2b rd latency", 32'(lat + 1), 32'd4);
        pop_check("b2b rd");
        tick();

        // Reset during WAIT aborts the write
        req = 1'b1; rw = 1'b1; addbus = 16'h0020; ramin = 32'hFFFF_FFFF;
        tick();
        req = 1'b0;
        tick();
        check("mid busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset ramout", ramout, 32'd0);
        rcnt = 0;
        for (int i = 0; i < 8; i++) begin
            rcnt += int'(ready);
            tick();
        end
        check("aborted no ready", 32'(rcnt), 32'd0);
        v = '{1'b0, 16'h0020, 32'h0, 32'h1111_1111, 1'b0};
        txn(v, "after abort");

        // Out-of-range address 0x0105
        v = '{1'b1, 16'h0105, 32'h22, 32'h1111_1111, BOUNDS};
        txn(v, "oor wr");
        v = '{1'b0, 16'h0005, 32'h0,
              BOUNDS ? 32'h0000_1000 : 32'h0000_0022, 1'b0};
        txn(v, "alias rd");
        v = '{1'b0, 16'h0105, 32'h0,
              BOUNDS ? 32'h0 : 32'h0000_0022, BOUNDS};
        txn(v, "oor rd");

        check("queue drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
